// File: rtl/div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_sequencer                                                |
// | Description : Queues divide requests in a 2-entry FIFO and sequences an    |
// |               external SRT divider (clear, launch, wait, respond), with a  |
// |               watchdog and divide-by-zero result substitution.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module div_sequencer #(
  parameter int N    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  // request side
  input  logic            reqValid,
  output logic            reqReady,
  input  logic            reqSigned,
  input  logic [N-1:0]    reqX,
  input  logic [N-1:0]    reqY,
  input  logic [TAGW-1:0] reqTag,
  // response side
  output logic            respValid,
  input  logic            respReady,
  output logic [N-1:0]    respQ,
  output logic [N-1:0]    respR,
  output logic            respDivByZero,
  output logic            respTimeout,
  output logic [TAGW-1:0] respTag,
  // divider side
  output logic            divRst,
  output logic            divStart,
  output logic            divSigned,
  output logic [N-1:0]    divX,
  output logic [N-1:0]    divY,
  input  logic [N-1:0]    divQ,
  input  logic [N-1:0]    divR,
  input  logic            divDone,
  input  logic            divDbz,
  // status
  output logic            busy
);

  // Watchdog fires on the (2N+8)-th WAIT cycle, i.e. when the count reads 2N+7.
  localparam int              WD_W     = $clog2(2 * N + 8 + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(2 * N + 7);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Request FIFO (2 entries)
  // ---------------------------------------------------------------------------
  logic            fifo_sgn [2];
  logic [N-1:0]    fifo_x   [2];
  logic [N-1:0]    fifo_y   [2];
  logic [TAGW-1:0] fifo_tag [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       ready_q;
  logic       push;
  logic       pop;
  logic       empty;

  assign empty    = (count == 2'd0);
  assign push     = reqValid & ready_q;
  assign pop      = (state == S_IDLE) & ~empty;
  assign reqReady = ready_q;

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (!push && pop) begin
      count_next = count - 2'd1;
    end
  end

  // FIFO pointers, count and registered ready (held low through reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // FIFO storage; contents are meaningless while count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sgn[wr_ptr] <= reqSigned;
      fifo_x[wr_ptr]   <= reqX;
      fifo_y[wr_ptr]   <= reqY;
      fifo_tag[wr_ptr] <= reqTag;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with operand register and registered outputs
  // ---------------------------------------------------------------------------
  logic            op_signed;
  logic [N-1:0]    op_x;
  logic [N-1:0]    op_y;
  logic [TAGW-1:0] op_tag;
  logic [WD_W-1:0] wdog;

  // Operands stay in op_* from CLEAR until WAIT exits, keeping divider inputs stable.
  assign divSigned = op_signed;
  assign divX      = op_x;
  assign divY      = op_y;
  assign busy      = (state != S_IDLE) | ~empty;

  // Control sequence: IDLE -> CLEAR -> LAUNCH -> WAIT -> RESP -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      op_signed     <= 1'b0;
      op_x          <= '0;
      op_y          <= '0;
      op_tag        <= '0;
      wdog          <= '0;
      divRst        <= 1'b1;
      divStart      <= 1'b0;
      respValid     <= 1'b0;
      respQ         <= '0;
      respR         <= '0;
      respDivByZero <= 1'b0;
      respTimeout   <= 1'b0;
      respTag       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            op_signed <= fifo_sgn[rd_ptr];
            op_x      <= fifo_x[rd_ptr];
            op_y      <= fifo_y[rd_ptr];
            op_tag    <= fifo_tag[rd_ptr];
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // divRst has been high for this one CLEAR cycle; release it and pulse start.
          divRst   <= 1'b0;
          divStart <= 1'b1;
          state    <= S_LAUNCH;
        end
        S_LAUNCH: begin
          divStart <= 1'b0;
          wdog     <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still wins over the watchdog.
          if (divDone) begin
            respValid   <= 1'b1;
            respTimeout <= 1'b0;
            respTag     <= op_tag;
            divRst      <= 1'b1;
            state       <= S_RESP;
            if (divDbz) begin
              respQ         <= '1;
              respR         <= op_x;
              respDivByZero <= 1'b1;
            end else begin
              respQ         <= divQ;
              respR         <= divR;
              respDivByZero <= 1'b0;
            end
          end else if (wdog == WD_LIMIT) begin
            respValid     <= 1'b1;
            respTimeout   <= 1'b1;
            respQ         <= '0;
            respR         <= '0;
            respDivByZero <= 1'b0;
            respTag       <= op_tag;
            divRst        <= 1'b1;
            state         <= S_RESP;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_RESP: begin
          if (respReady) begin
            respValid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          divRst <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_div_sequencer                                             |
// | Description : Self-checking bench for div_sequencer with a behavioural     |
// |               divider model (done N+3 cycles after start, 2 for y=0).      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_div_sequencer;

  localparam int N    = 32;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            reqValid = 1'b0;
  logic            reqReady;
  logic            reqSigned = 1'b0;
  logic [N-1:0]    reqX = '0;
  logic [N-1:0]    reqY = '0;
  logic [TAGW-1:0] reqTag = '0;
  logic            respValid;
  logic            respReady = 1'b0;
  logic [N-1:0]    respQ;
  logic [N-1:0]    respR;
  logic            respDivByZero;
  logic            respTimeout;
  logic [TAGW-1:0] respTag;
  logic            divRst;
  logic            divStart;
  logic            divSigned;
  logic [N-1:0]    divX;
  logic [N-1:0]    divY;
  logic [N-1:0]    divQ = '0;
  logic [N-1:0]    divR = '0;
  logic            divDone = 1'b0;
  logic            divDbz = 1'b0;
  logic            busy;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  bit hang  = 1'b0;

  div_sequencer #(.N(N), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqSigned(reqSigned),
    .reqX(reqX), .reqY(reqY), .reqTag(reqTag),
    .respValid(respValid), .respReady(respReady), .respQ(respQ), .respR(respR),
    .respDivByZero(respDivByZero), .respTimeout(respTimeout), .respTag(respTag),
    .divRst(divRst), .divStart(divStart), .divSigned(divSigned),
    .divX(divX), .divY(divY), .divQ(divQ), .divR(divR),
    .divDone(divDone), .divDbz(divDbz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter, read only on falling edges.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } res_t;

  // Reference division: truncating quotient, remainder takes the dividend's sign.
  function automatic res_t ref_div(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y);
    res_t   o;
    longint sx;
    longint sy;
    if (y == '0) begin
      o.q = '1; o.r = x; o.dbz = 1'b1;
    end else if (!sgn) begin
      o.q = x / y; o.r = x % y; o.dbz = 1'b0;
    end else begin
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      o.q = N'(sx / sy); o.r = N'(sx % sy); o.dbz = 1'b0;
    end
    return o;
  endfunction

  // Divider model: latches operands on start, raises done after a fixed delay.
  logic         dv_busy = 1'b0;
  int           dv_cnt  = 0;
  logic         dv_sgn  = 1'b0;
  logic [N-1:0] dv_x    = '0;
  logic [N-1:0] dv_y    = '0;
  res_t         dv_res;
  assign dv_res = ref_div(dv_sgn, dv_x, dv_y);

  always @(posedge clk) begin
    if (divRst) begin
      dv_busy <= 1'b0; dv_cnt <= 0; divDone <= 1'b0; divDbz <= 1'b0;
      divQ <= '0; divR <= '0;
    end else if (divStart) begin
      dv_busy <= 1'b1;
      dv_cnt  <= (divY == '0) ? 2 : N + 3;
      dv_sgn  <= divSigned; dv_x <= divX; dv_y <= divY;
    end else if (dv_busy && !hang) begin
      if (dv_cnt == 1) begin
        divDone <= 1'b1;
        divDbz  <= dv_res.dbz;
        // Garbage on divide-by-zero so the sequencer's own substitution is exercised.
        divQ    <= dv_res.dbz ? 32'h5A5A_5A5A : dv_res.q;
        divR    <= dv_res.dbz ? 32'hA5A5_A5A5 : dv_res.r;
        dv_busy <= 1'b0;
      end
      dv_cnt <= dv_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [TAGW-1:0] tag, output int t);
    int n = 0;
    while (!reqReady && n < 100) begin @(negedge clk); n++; end
    chk("reqReady before push", reqReady, 1);
    reqValid = 1'b1; reqSigned = sgn; reqX = x; reqY = y; reqTag = tag;
    @(negedge clk);
    reqValid = 1'b0;
    t = cyc;
  endtask

  task automatic wait_resp(input string nm, output bit ok);
    int n = 0;
    while (!respValid && n < 200) begin @(negedge clk); n++; end
    ok = respValid;
    if (!ok) chk({nm, " respValid wait"}, respValid, 1);
  endtask

  task automatic run_one(input string nm, input logic sgn, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic [TAGW-1:0] tag,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edbz, input logic eto, input int elat);
    int t;
    bit ok;
    push_req(sgn, x, y, tag, t);
    wait_resp(nm, ok);
    if (ok) begin
      chk({nm, " latency"}, 64'(cyc - t), 64'(elat));
      chk({nm, " q"}, respQ, eq);
      chk({nm, " r"}, respR, er);
      chk({nm, " dbz"}, respDivByZero, edbz);
      chk({nm, " timeout"}, respTimeout, eto);
      chk({nm, " tag"}, respTag, tag);
      respReady = 1'b1;
      @(negedge clk);
      respReady = 1'b0;
      chk({nm, " valid drop"}, respValid, 0);
    end
  endtask

  typedef struct {
    logic            sgn;
    logic [N-1:0]    x;
    logic [N-1:0]    y;
    logic [TAGW-1:0] tag;
    logic [N-1:0]    eq;
    logic [N-1:0]    er;
    logic            edbz;
    int              elat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #300000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   t;
    bit   ok;
    bit   seen;
    res_t e;
    logic            s;
    logic [N-1:0]    rx;
    logic [N-1:0]    ry;
    logic [TAGW-1:0] rt;
    logic [N-1:0]    bx[3];
    logic [N-1:0]    by[3];

    vecs[0] = '{1'b0, 32'd100,       32'd7,         4'd3, 32'd14,        32'd2,         1'b0, 39};
    vecs[1] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 4'd4, 32'hFFFF_FFF2, 32'd2,         1'b0, 39};
    vecs[2] = '{1'b0, 32'h1234,      32'd0,         4'd5, 32'hFFFF_FFFF, 32'h1234,      1'b1, 6};
    vecs[3] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         4'd6, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 39};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         4'd7, 32'hFFFF_FFFF, 32'd0,         1'b0, 39};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 32'h8000_0000, 32'd0,         1'b0, 39};
    vecs[6] = '{1'b1, 32'h8000_0001, 32'd0,         4'd9, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 6};
    vecs[7] = '{1'b0, 32'd5,         32'd9,         4'hA, 32'd0,         32'd5,         1'b0, 39};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset reqReady", reqReady, 0);
    chk("reset respValid", respValid, 0);
    chk("reset divRst", divRst, 1);
    chk("reset divStart", divStart, 0);
    chk("reset busy", busy, 0);
    chk("reset respQ", respQ, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("reqReady after reset", reqReady, 1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].x, vecs[i].y, vecs[i].tag,
              vecs[i].eq, vecs[i].er, vecs[i].edbz, 1'b0, vecs[i].elat);
    end

    // Randomized against the reference model
    for (int i = 0; i < 24; i++) begin
      s  = 1'($urandom_range(0, 1));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = N'($urandom_range(1, 15));
        2:       ry = $urandom;
        default: ry = '1;
      endcase
      rt = TAGW'($urandom_range(0, 15));
      e  = ref_div(s, rx, ry);
      run_one($sformatf("rnd%0d", i), s, rx, ry, rt, e.q, e.r, e.dbz, 1'b0,
              (ry == '0) ? 6 : N + 7);
    end

    // Back-to-back with a stalled consumer: results in tag order, ready drops when full
    bx[0] = 32'd100;  by[0] = 32'd7;
    bx[1] = 32'd1000; by[1] = 32'd33;
    bx[2] = 32'd7;    by[2] = 32'd0;
    for (int k = 0; k < 3; k++) push_req(1'b0, bx[k], by[k], TAGW'(k + 1), t);
    chk("b2b reqReady when full", reqReady, 0);
    chk("b2b busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      e = ref_div(1'b0, bx[k], by[k]);
      wait_resp($sformatf("b2b%0d", k), ok);
      if (ok) begin
        chk($sformatf("b2b%0d tag", k), respTag, k + 1);
        chk($sformatf("b2b%0d q", k), respQ, e.q);
        chk($sformatf("b2b%0d r", k), respR, e.r);
        repeat (10) @(negedge clk);
        chk($sformatf("b2b%0d held valid", k), respValid, 1);
        chk($sformatf("b2b%0d held tag", k), respTag, k + 1);
        respReady = 1'b1;
        @(negedge clk);
        respReady = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("b2b idle after drain", busy, 0);

    // Watchdog: divider never finishes
    hang = 1'b1;
    run_one("timeout", 1'b0, 32'd50, 32'd5, 4'hB, 32'd0, 32'd0, 1'b0, 1'b1, 2 * N + 11);
    hang = 1'b0;

    // Reset mid-operation with a second request queued
    push_req(1'b0, 32'd100, 32'd3, 4'hC, t);
    push_req(1'b0, 32'd200, 32'd3, 4'hD, t);
    repeat (8) @(negedge clk);
    chk("midrst busy before", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst respValid", respValid, 0);
    chk("midrst reqReady", reqReady, 0);
    chk("midrst busy", busy, 0);
    chk("midrst divRst", divRst, 1);
    chk("midrst divStart", divStart, 0);
    chk("midrst respTag", respTag, 0);
    chk("midrst respTimeout", respTimeout, 0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (respValid) seen = 1'b1;
    end
    chk("midrst no stale response", seen, 0);
    run_one("after midrst", 1'b0, 32'd100, 32'd7, 4'hE, 32'd14, 32'd2, 1'b0, 1'b0, N + 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
